// File: rtl/muldiv_sequencer_if.sv
// Request/response, architectural HI/LO and arithmetic-unit handshake bundle for muldiv_sequencer.
// slave = the sequencer's view; master = the control unit and arithmetic unit driving it.
interface muldiv_sequencer_if;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        op_done;
  logic        div_zero_exc;
  logic        timeout_err;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        md_start;
  logic        md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        md_done;
  logic [31:0] md_hi;
  logic [31:0] md_lo;
  logic        md_div_zero;

  modport slave (
    input  req_valid, req_op, rs_val, rt_val, md_done, md_hi, md_lo, md_div_zero,
    output ready, resp_valid, resp_data, op_done, div_zero_exc, timeout_err, hi, lo,
           md_start, md_op, md_a, md_b
  );

  modport master (
    output req_valid, req_op, rs_val, rt_val, md_done, md_hi, md_lo, md_div_zero,
    input  ready, resp_valid, resp_data, op_done, div_zero_exc, timeout_err, hi, lo,
           md_start, md_op, md_a, md_b
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Issues MULT/DIV to the iterative arithmetic unit, commits HI/LO under a watchdog, and serves MFHI/MFLO.
// MULT/DIV: op_done two cycles after md_done is first seen in WAIT; MFHI/MFLO: resp_valid the cycle after accept; ready only in IDLE.
module muldiv_sequencer #(
  parameter int TIMEOUT = 48
) (
  input  logic               clk,
  input  logic               reset,
  muldiv_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_COMMIT,
    S_READ
  } state_t;

  localparam logic [5:0] WD_LAST = 6'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [5:0]  wdog;
  logic [31:0] cap_hi, cap_lo;
  logic        cap_dz;
  logic        wd_expire;

  logic accept_md, accept_rd, capture, commit_upd;
  logic op_done_d, dz_exc_d, timeout_d;

  // wdog counts completed WAIT cycles; the abort edge is the end of the TIMEOUT-th one.
  assign wd_expire = (wdog == WD_LAST);
  assign bus.ready = (state == S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.req_valid) state_nxt = bus.req_op[1] ? S_READ : S_ISSUE;
      S_ISSUE:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.md_done)     state_nxt = S_COMMIT;
        else if (wd_expire)  state_nxt = S_IDLE;
      end
      S_COMMIT: state_nxt = S_IDLE;
      S_READ:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    accept_md  = 1'b0;
    accept_rd  = 1'b0;
    capture    = 1'b0;
    commit_upd = 1'b0;
    op_done_d  = 1'b0;
    dz_exc_d   = 1'b0;
    timeout_d  = 1'b0;
    case (state)
      S_IDLE: begin
        accept_md = bus.req_valid && !bus.req_op[1];
        accept_rd = bus.req_valid &&  bus.req_op[1];
      end
      S_WAIT: begin
        // Completion in the expiry cycle takes priority over the abort.
        if (bus.md_done) begin
          capture = 1'b1;
        end else if (wd_expire) begin
          op_done_d = 1'b1;
          timeout_d = 1'b1;
        end
      end
      S_COMMIT: begin
        op_done_d = 1'b1;
        if (cap_dz && !bus.md_op) dz_exc_d   = 1'b1;
        else                      commit_upd = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.md_start     <= 1'b0;
      bus.md_op        <= 1'b0;
      bus.md_a         <= '0;
      bus.md_b         <= '0;
      bus.resp_valid   <= 1'b0;
      bus.resp_data    <= '0;
      bus.op_done      <= 1'b0;
      bus.div_zero_exc <= 1'b0;
      bus.timeout_err  <= 1'b0;
      bus.hi           <= '0;
      bus.lo           <= '0;
      wdog             <= '0;
      cap_hi           <= '0;
      cap_lo           <= '0;
      cap_dz           <= 1'b0;
    end else begin
      bus.md_start     <= accept_md;
      bus.resp_valid   <= accept_rd;
      bus.op_done      <= op_done_d;
      bus.div_zero_exc <= dz_exc_d;
      bus.timeout_err  <= timeout_d;
      if (accept_md) begin
        bus.md_a  <= bus.rs_val;
        bus.md_b  <= bus.rt_val;
        bus.md_op <= (bus.req_op == 2'b00);
      end
      // HI/LO cannot change while a read is outstanding, so sample at accept.
      if (accept_rd) bus.resp_data <= bus.req_op[0] ? bus.lo : bus.hi;
      if (state == S_ISSUE)     wdog <= '0;
      else if (state == S_WAIT) wdog <= wdog + 6'd1;
      if (capture) begin
        cap_hi <= bus.md_hi;
        cap_lo <= bus.md_lo;
        cap_dz <= bus.md_div_zero;
      end
      if (commit_upd) begin
        bus.hi <= cap_hi;
        bus.lo <= cap_lo;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed scoreboard bench for muldiv_sequencer: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_muldiv_sequencer;
  localparam int TIMEOUT = 48;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  muldiv_sequencer_if bus();

  muldiv_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit          is_resp;
    logic [31:0] data;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          dz;
    bit          to;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: every op_done/resp_valid pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset && (bus.op_done || bus.resp_valid)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {62'd0, bus.op_done, bus.resp_valid}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_valid", bus.resp_valid, mon_e.is_resp);
        chk("op_done", bus.op_done, !mon_e.is_resp);
        chk("pulse_cycle", cyc, mon_e.cyc);
        if (mon_e.is_resp) begin
          chk("resp_data", bus.resp_data, mon_e.data);
        end else begin
          chk("hi", bus.hi, mon_e.hi);
          chk("lo", bus.lo, mon_e.lo);
          chk("div_zero_exc", bus.div_zero_exc, mon_e.dz);
          chk("timeout_err", bus.timeout_err, mon_e.to);
        end
      end
    end
    if (reset && !bus.op_done && (bus.div_zero_exc || bus.timeout_err))
      chk("flag_without_op_done", {bus.div_zero_exc, bus.timeout_err}, 2'b00);
  end

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, output int t);
    int guard = 0;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.rs_val    = a;
    bus.rt_val    = b;
    @(negedge clk);
    while (!bus.ready) begin
      guard++;
      if (guard > 200) begin
        $display("FAIL ready_wait: ready stayed 0 for %0d cycles, expected 1", guard);
        $fatal(1);
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    t = cyc;
    bus.req_valid = 1'b0;
  endtask

  // k = cycles after ISSUE until md_done is presented (0 = never); early holds md_done high through ISSUE.
  task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int k, input logic [31:0] rhi, input logic [31:0] rlo, input logic rdz,
                        input bit early);
    int   t;
    int   starts = 0;
    int   rdy = 0;
    int   lim;
    exp_t e;
    send(op, a, b, t);
    chk({nm, "_md_start"}, bus.md_start, 1'b1);
    chk({nm, "_md_op"}, bus.md_op, op == 2'b00);
    chk({nm, "_md_a"}, bus.md_a, a);
    chk({nm, "_md_b"}, bus.md_b, b);
    e.is_resp = 1'b0;
    e.data    = '0;
    e.dz      = 1'b0;
    e.to      = 1'b0;
    if (k == 0) begin
      e.to  = 1'b1;
      e.cyc = t + 1 + TIMEOUT;
    end else begin
      e.cyc = t + 2 + k;
      if (rdz && op == 2'b01) e.dz = 1'b1;
      else begin
        m_hi = rhi;
        m_lo = rlo;
      end
    end
    e.hi = m_hi;
    e.lo = m_lo;
    exp_q.push_back(e);
    if (early) begin
      bus.md_done = 1'b1;
      bus.md_hi   = 32'hDEAD_BEEF;
      bus.md_lo   = 32'hBAD0_BAD0;
    end
    lim = (k == 0) ? TIMEOUT : k;
    for (int i = 1; i <= lim; i++) begin
      @(posedge clk);
      #1;
      if (bus.md_start) starts++;
      if (bus.ready) rdy++;
      if (i == 1) bus.md_done = 1'b0;
      if (i == k) begin
        bus.md_done     = 1'b1;
        bus.md_hi       = rhi;
        bus.md_lo       = rlo;
        bus.md_div_zero = rdz;
      end
    end
    @(posedge clk);
    #1;
    bus.md_done     = 1'b0;
    bus.md_div_zero = 1'b0;
    if (k != 0) begin
      @(posedge clk);
      #1;
    end
    chk({nm, "_extra_md_start"}, starts, 0);
    chk({nm, "_ready_while_busy"}, rdy, 0);
  endtask

  task automatic read(input logic [1:0] op);
    int   t;
    exp_t e;
    send(op, 32'h0, 32'h0, t);
    e.is_resp = 1'b1;
    e.data    = op[0] ? m_lo : m_hi;
    e.hi      = m_hi;
    e.lo      = m_lo;
    e.dz      = 1'b0;
    e.to      = 1'b0;
    e.cyc     = t;
    exp_q.push_back(e);
  endtask

  initial begin
    int t;
    bus.req_valid   = 1'b0;
    bus.req_op      = 2'b00;
    bus.rs_val      = '0;
    bus.rt_val      = '0;
    bus.md_done     = 1'b0;
    bus.md_hi       = '0;
    bus.md_lo       = '0;
    bus.md_div_zero = 1'b0;
    #1 reset = 1'b0;
    #2;
    chk("rst_ready", bus.ready, 1'b1);
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    chk("rst_md_a", bus.md_a, 32'h0);
    chk("rst_md_b", bus.md_b, 32'h0);
    chk("rst_md_op", bus.md_op, 1'b0);
    chk("rst_resp_data", bus.resp_data, 32'h0);
    chk("rst_pulses", {bus.md_start, bus.op_done, bus.resp_valid, bus.div_zero_exc, bus.timeout_err}, 5'b0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;

    run_op("mult", 2'b00, 32'd3, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 1'b0);
    run_op("div0", 2'b01, 32'd7, 32'd0, 4, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0);
    run_op("mult_dz_ignored", 2'b00, 32'd2, 32'd3, 2, 32'h0, 32'h6, 1'b1, 1'b0);
    run_op("div", 2'b01, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
    read(2'b11);
    read(2'b10);
    run_op("timeout", 2'b00, 32'd5, 32'd5, 0, 32'h0, 32'h0, 1'b0, 1'b0);
    read(2'b10);
    run_op("early_done", 2'b00, 32'd6, 32'd7, 5, 32'h0, 32'h2A, 1'b0, 1'b1);
    run_op("expiry_done", 2'b00, 32'h1_0000, 32'h1_0000, TIMEOUT, 32'h1, 32'h0, 1'b0, 1'b0);
    read(2'b11);

    // Asynchronous reset in the middle of WAIT, then a stale completion.
    send(2'b00, 32'd5, 32'd6, t);
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("arst_ready", bus.ready, 1'b1);
    chk("arst_hi", bus.hi, 32'h0);
    chk("arst_lo", bus.lo, 32'h0);
    chk("arst_md_start", bus.md_start, 1'b0);
    m_hi = '0;
    m_lo = '0;
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    bus.md_done = 1'b1;
    bus.md_hi   = 32'hFFFF_0000;
    bus.md_lo   = 32'h0000_FFFF;
    repeat (3) @(posedge clk);
    #1 bus.md_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("stale_hi", bus.hi, 32'h0);
    chk("stale_lo", bus.lo, 32'h0);
    chk("stale_ready", bus.ready, 1'b1);
    read(2'b10);
    read(2'b11);

    repeat (5) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Issue-and-commit sequencer that sits between the multicycle control unit and the iterative multiply/divide datapath. It accepts MULT/DIV/MFHI/MFLO requests and drives the start/operand side of the arithmetic unit. It waits for completion under a watchdog, then commits the result into the architectural HI/LO registers or raises a divide-by-zero exception. It also serves MFHI/MFLO reads, stalling them until any in-flight operation has committed.

## Interface
- `TIMEOUT`, 48: maximum cycles spent in WAIT before aborting; range 2..63.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-low; clears all state and outputs immediately.
- `req_valid` input 1: control unit presents a request this cycle.
- `req_op` input 2: 00 MULT, 01 DIV, 10 MFHI, 11 MFLO.
- `rs_val` input 32: first operand (multiplicand / dividend).
- `rt_val` input 32: second operand (multiplier / divisor).
- `ready` output 1: high only in IDLE; a request is accepted iff `req_valid && ready` at a clock edge.
- `resp_valid` output 1: one-cycle pulse; `resp_data` valid (MFHI/MFLO).
- `resp_data` output 32: HI or LO value read.
- `op_done` output 1: one-cycle pulse when a MULT/DIV commits or aborts.
- `div_zero_exc` output 1: one-cycle pulse, coincident with `op_done`, for DIV by zero.
- `timeout_err` output 1: one-cycle pulse, coincident with `op_done`, on watchdog expiry.
- `hi`, `lo` output 32 each: architectural HI/LO registers.
- `md_start` output 1: one-cycle launch pulse to the arithmetic unit.
- `md_op` output 1: 1 = multiply, 0 = divide; held from ISSUE through WAIT.
- `md_a`, `md_b` output 32 each: operands, held stable from ISSUE through WAIT.
- `md_done` input 1: arithmetic unit result ready (pulse or level).
- `md_hi`, `md_lo` input 32 each: unit result (mult: product high/low; div: quotient/remainder per datapath convention).
- `md_div_zero` input 1: divisor was zero; qualified by `md_done`.

## Operation
- States: IDLE, ISSUE, WAIT, COMMIT, READ.
- **IDLE:** `ready`=1.
  - MULT/DIV accepted: latch operands into `md_a`/`md_b`, set `md_op` = (req_op==00), go to ISSUE.
  - MFHI/MFLO accepted: latch the selector, go to READ.
- **ISSUE:** `md_start`=1 for exactly this cycle. Clear the watchdog to 0 and go to WAIT.
- **WAIT:**
  - Each cycle, watchdog +1.
  - First cycle `md_done`=1: capture `md_hi`, `md_lo` and `md_div_zero` into holding regs and go to COMMIT.
  - If the watchdog reaches TIMEOUT without `md_done`: pulse `op_done` and `timeout_err`, leave `hi`/`lo` unchanged, go to IDLE.
- **COMMIT:**
  - If the captured div_zero is set and `md_op`=0: `hi`/`lo` unchanged, pulse `div_zero_exc`.
  - Otherwise: `hi` <= captured hi, `lo` <= captured lo.
  - Pulse `op_done`, go to IDLE.
- **READ:** `resp_data` = `hi` (MFHI) or `lo` (MFLO), pulse `resp_valid`, go to IDLE.
- `md_div_zero` is ignored for MULT. `md_done` is ignored outside WAIT, including a stale level held across IDLE/ISSUE.
- `req_valid` while `ready`=0 is ignored; the control unit must hold or replay it.

## Timing
- Reset values: state IDLE, `ready`=1, `hi`=`lo`=0, `md_a`=`md_b`=0, `md_op`=0, `resp_data`=0, watchdog 0, all pulses 0.
- Outputs are registered.
- MULT/DIV latency:
  - Accept edge T; `md_start` high in T+1 (ISSUE).
  - `md_done` first seen high at edge T+1+k (k≥1) takes the FSM to COMMIT.
  - `hi`/`lo` update and `op_done` occur at edge T+2+k; `ready` returns the same cycle.
- MFHI/MFLO: accept edge T; `resp_valid` and `resp_data` are high during cycle T+1; `ready` is high again in cycle T+2.
- MFHI issued behind a MULT: stalled by `ready`=0 until after COMMIT, so it always returns the new value.
- Watchdog: if `md_done` never arrives, `timeout_err` is asserted exactly TIMEOUT cycles after the ISSUE cycle.
- `md_done` high in the same cycle the watchdog expires: completion wins and the FSM goes to COMMIT.
- Reset asserted mid-WAIT: the FSM goes to IDLE at once, `hi`/`lo` clear to 0, and no `op_done` pulse is emitted. The arithmetic unit is reset by the same net.
- Back-to-back: a new request may be accepted in the same cycle `op_done`/`resp_valid` is high (FSM already in IDLE).

## Test plan
- Reset release, then MULT rs=3 rt=0xFFFFFFFE; stub returns hi=0xFFFFFFFF lo=0xFFFFFFFA after k=33 cycles -> `md_start` pulses once with `md_op`=1; `hi`/`lo` update with `op_done` at accept+35; `ready` is low throughout.
- DIV rs=7 rt=0; stub returns `md_div_zero`=1 and junk hi/lo -> `div_zero_exc`+`op_done` pulse; `hi`/`lo` keep their prior values.
- DIV 0xFFFFFFF9 / 2; stub returns hi=0xFFFFFFFD lo=0xFFFFFFFF -> committed verbatim; then MFLO -> `resp_data`=0xFFFFFFFF, `resp_valid` exactly one cycle.
- MULT with the stub never asserting `md_done`, TIMEOUT=48 -> `timeout_err`+`op_done` 48 cycles after ISSUE; `hi`/`lo` unchanged; the next MFHI is served normally.
- Timing corner cases:
  - `md_done` held high during the ISSUE cycle -> ignored; completion is taken only from WAIT.
  - `md_done` arriving in the watchdog-expiry cycle -> commit, no `timeout_err`.
- Reset pulsed low asynchronously mid-WAIT (between edges) -> `ready`=1 and `hi`=`lo`=0 immediately; a later stale `md_done` causes no commit.
